// File: rtl/packet_fifo.sv
// Packet-mode synchronous FIFO: words are staged speculatively and become
// visible to the reader only once the packet's last word is committed.
module packet_fifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_last,
    input  logic              i_drop,
    input  logic [LGFLEN:0]   i_afull_thr,
    input  logic [LGFLEN:0]   i_aempty_thr,
    output logic              o_full,
    output logic [LGFLEN:0]   o_wfill,
    output logic              o_afull,
    output logic              o_pkt_dropped,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_aempty,
    output logic [LGFLEN:0]   o_pkt_cnt
);
    localparam int FLEN = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FLEN_W = (LGFLEN+1)'(FLEN);

    logic [LGFLEN:0] wr_spec, wr_commit, rd_ptr, pkt_cnt;
    logic            ovf, pkt_dropped;
    logic [BW:0]     mem [0:FLEN-1];
    logic [BW:0]     head;
    logic            w_wr, w_rd, w_commit, w_autodrop, w_drop, w_ovf_set, w_rd_last;

    assign o_wfill       = wr_spec - rd_ptr;
    assign o_fill        = wr_commit - rd_ptr;
    assign o_full        = (o_wfill == FLEN_W);
    assign o_empty       = (wr_commit == rd_ptr);
    assign o_afull       = (o_wfill >= i_afull_thr);
    assign o_aempty      = (o_fill <= i_aempty_thr);
    assign o_pkt_cnt     = pkt_cnt;
    assign o_pkt_dropped = pkt_dropped;

    assign head   = mem[rd_ptr[LGFLEN-1:0]];
    assign o_data = head[BW-1:0];
    assign o_last = head[BW];

    // A drop also counts as effective when the packet has only lost words
    // (ovf set with nothing staged), so the overflow state is always cleared.
    assign w_drop     = i_drop & ((wr_spec != wr_commit) | ovf);
    assign w_wr       = i_wr & ~o_full & ~i_drop & ~ovf;
    assign w_commit   = w_wr & i_last;
    assign w_autodrop = i_wr & i_last & (ovf | o_full) & ~i_drop;
    assign w_ovf_set  = i_wr & o_full & ~i_drop & ~i_last;
    assign w_rd       = i_rd & ~o_empty;
    assign w_rd_last  = w_rd & head[BW];

    always_ff @(posedge i_clk) begin
        if (w_wr)
            mem[wr_spec[LGFLEN-1:0]] <= {i_last, i_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_spec     <= '0;
            wr_commit   <= '0;
            rd_ptr      <= '0;
            pkt_cnt     <= '0;
            ovf         <= 1'b0;
            pkt_dropped <= 1'b0;
        end else begin
            if (w_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (w_drop | w_autodrop) begin
                wr_spec <= wr_commit;
                ovf     <= 1'b0;
            end else begin
                if (w_wr)
                    wr_spec <= wr_spec + 1'b1;
                if (w_ovf_set)
                    ovf <= 1'b1;
            end
            if (w_commit)
                wr_commit <= wr_spec + 1'b1;
            pkt_dropped <= w_drop | w_autodrop;
            // commit and last-word read in the same cycle cancel out
            case ({w_commit, w_rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_fifo.sv
// Scoreboard bench for packet_fifo: a queue-based packet model predicts the
// flags each cycle, and a monitor checks every word the reader pops.
module tb_packet_fifo;
    localparam int BW = 8, LGFLEN = 4, FLEN = 16;

    logic              i_clk = 1'b0;
    logic              i_reset, i_wr, i_last, i_drop, i_rd;
    logic [BW-1:0]     i_data;
    logic [LGFLEN:0]   i_afull_thr, i_aempty_thr;
    logic              o_full, o_afull, o_pkt_dropped, o_last, o_empty, o_aempty;
    logic [LGFLEN:0]   o_wfill, o_fill, o_pkt_cnt;
    logic [BW-1:0]     o_data;

    packet_fifo #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
        .i_last(i_last), .i_drop(i_drop), .i_afull_thr(i_afull_thr),
        .i_aempty_thr(i_aempty_thr), .o_full(o_full), .o_wfill(o_wfill),
        .o_afull(o_afull), .o_pkt_dropped(o_pkt_dropped), .i_rd(i_rd),
        .o_data(o_data), .o_last(o_last), .o_empty(o_empty), .o_fill(o_fill),
        .o_aempty(o_aempty), .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [BW:0] cq[$];     // committed words, {last, data}
    logic [BW:0] uq[$];     // staged words of the open packet
    logic [BW:0] exp_q[$];  // words the reader is expected to see
    logic [BW:0] mon_e;
    bit          m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reader-side monitor: inputs change just after posedge, so negedge sees
    // the read request and head word that the next posedge will consume.
    always @(negedge i_clk) begin
        if (!i_reset && i_rd && !o_empty) begin
            if (exp_q.size() == 0)
                check("rd_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("rd_data", int'(o_data), int'(mon_e[BW-1:0]));
                check("rd_last", int'(o_last), int'(mon_e[BW]));
            end
        end
    end

    task automatic check_state(input bit dropped);
        int fill, wf, pk;
        fill = cq.size();
        wf   = fill + uq.size();
        pk   = 0;
        foreach (cq[k]) if (cq[k][BW]) pk++;
        check("fill",        int'(o_fill),        fill);
        check("wfill",       int'(o_wfill),       wf);
        check("full",        int'(o_full),        int'(wf == FLEN));
        check("empty",       int'(o_empty),       int'(fill == 0));
        check("afull",       int'(o_afull),       int'(wf >= int'(i_afull_thr)));
        check("aempty",      int'(o_aempty),      int'(fill <= int'(i_aempty_thr)));
        check("pkt_cnt",     int'(o_pkt_cnt),     pk);
        check("pkt_dropped", int'(o_pkt_dropped), int'(dropped));
    endtask

    task automatic cycle(input bit wr, input logic [BW-1:0] d, input bit last,
                         input bit drop, input bit rd);
        bit full, empty, dropped;
        i_wr = wr; i_data = d; i_last = last; i_drop = drop; i_rd = rd;
        @(posedge i_clk);
        #1;
        full    = (cq.size() + uq.size()) == FLEN;
        empty   = (cq.size() == 0);
        dropped = 1'b0;
        if (rd && !empty) void'(cq.pop_front());
        if (drop) begin
            if (uq.size() > 0 || m_ovf) dropped = 1'b1;
            uq.delete();
            m_ovf = 1'b0;
        end else if (wr) begin
            if (full || m_ovf) begin
                if (last) begin
                    uq.delete();
                    m_ovf   = 1'b0;
                    dropped = 1'b1;
                end else
                    m_ovf = 1'b1;
            end else begin
                uq.push_back({last, d});
                if (last) begin
                    foreach (uq[k]) begin
                        cq.push_back(uq[k]);
                        exp_q.push_back(uq[k]);
                    end
                    uq.delete();
                end
            end
        end
        i_wr = 1'b0; i_last = 1'b0; i_drop = 1'b0; i_rd = 1'b0;
        check_state(dropped);
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_wr = 1'b0; i_last = 1'b0; i_drop = 1'b0; i_rd = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        cq.delete(); uq.delete(); exp_q.delete();
        m_ovf = 1'b0;
        check_state(1'b0);
    endtask

    task automatic write_pkt(input int len, input int base);
        for (int k = 0; k < len; k++)
            cycle(1'b1, 8'(base + k), k == len - 1, 1'b0, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && cq.size() > 0; k++)
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        i_reset = 1'b1; i_wr = 1'b0; i_data = '0; i_last = 1'b0;
        i_drop = 1'b0; i_rd = 1'b0;
        i_afull_thr = 5'd12; i_aempty_thr = 5'd2;
        m_ovf = 1'b0;
        @(posedge i_clk);
        do_reset();

        // basic 3-word packet, then read it back
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // committed 4-word packet, then an explicitly dropped partial one
        write_pkt(4, 8'h40);
        write_pkt(2, 8'h50);   // len 2 would commit; re-stage as partial below
        drain(10);
        write_pkt(4, 8'h60);
        cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h72, 1'b1, 1'b1, 1'b0);   // drop wins over same-cycle last
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);   // drop with nothing staged
        drain(10);

        // overflow: 10 committed words, then a 9-word packet auto-drops
        write_pkt(10, 8'h80);
        write_pkt(9, 8'hA0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain(20);

        // packet longer than FLEN into an empty FIFO
        write_pkt(FLEN + 3, 8'hC0);
        drain(20);

        // read coincident with commit into an empty FIFO
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 40 one-word packets with interleaved reads
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, 8'(k), 1'b1, 1'b0, k % 3 != 0);
            if (k % 4 == 0) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        drain(40);

        // mid-packet reset discards staged and committed words
        write_pkt(3, 8'hD0);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // randomized traffic with moving thresholds
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) begin
                i_afull_thr  = 5'($urandom_range(0, FLEN));
                i_aempty_thr = 5'($urandom_range(0, FLEN));
            end
            cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < (k % 512 < 256 ? 30 : 70));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain(40);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
